// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low hex keypad, debounces whole-matrix frames and drives
// the debounced key bus plus a one-shot press event for the CPU.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  row_out,
  input  logic [3:0]  col_in,
  output logic [15:0] keys,
  output logic        key_event,
  output logic [3:0]  key_code,
  input  logic        key_ack
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Physical (row, col) position to hex key number.
  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_of = 4'h1;
      4'h1: key_of = 4'h2;
      4'h2: key_of = 4'h3;
      4'h3: key_of = 4'hC;
      4'h4: key_of = 4'h4;
      4'h5: key_of = 4'h5;
      4'h6: key_of = 4'h6;
      4'h7: key_of = 4'hD;
      4'h8: key_of = 4'h7;
      4'h9: key_of = 4'h8;
      4'hA: key_of = 4'h9;
      4'hB: key_of = 4'hE;
      4'hC: key_of = 4'hA;
      4'hD: key_of = 4'h0;
      4'hE: key_of = 4'hB;
      4'hF: key_of = 4'hF;
    endcase
  endfunction

  logic [3:0]    col_s1;
  logic [3:0]    col_s2;
  logic [3:0]    cols_now;
  logic [PW-1:0] prescale;
  logic [1:0]    row;
  logic [3:0]    raw [3];
  logic [3:0]    row_bits [4];
  logic          sample;
  logic          commit;
  logic [15:0]   frame;
  logic [15:0]   prev_frame;
  logic          same;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] stable_next;
  logic          keys_upd;
  logic [15:0]   new_keys;
  logic [3:0]    new_low;
  logic          ack_ok;
  logic          event_next;
  logic [3:0]    code_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_s1 <= '0;
      col_s2 <= '0;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
    end
  end

  assign cols_now = ~col_s2;
  assign sample   = (prescale == PRE_LAST);
  assign commit   = sample && (row == 2'd3);
  assign row_out  = ~(4'b0001 << row);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      row      <= '0;
      for (int r = 0; r < 3; r++) raw[r] <= '0;
    end else if (sample) begin
      prescale <= '0;
      row      <= row + 2'd1;
      for (int r = 0; r < 3; r++) begin
        if (row == 2'(r)) raw[r] <= cols_now;
      end
    end else begin
      prescale <= prescale + PW'(1);
    end
  end

  // Row 3 is taken straight from the synchronizer so the frame is complete
  // on the very edge that samples it.
  always_comb begin
    for (int r = 0; r < 3; r++) row_bits[r] = raw[r];
    row_bits[3] = cols_now;
    frame = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        frame[key_of(2'(r), 2'(c))] = row_bits[r][c];
      end
    end
  end

  assign same = (frame == prev_frame);

  always_comb begin
    stable_next = stable_cnt;
    keys_upd    = 1'b0;
    if (commit) begin
      if (!same) begin
        stable_next = CNT_ONE;
        keys_upd    = (CNT_ONE == CNT_MAX);
      end else if (stable_cnt != CNT_MAX) begin
        stable_next = stable_cnt + CNT_ONE;
        keys_upd    = ((stable_cnt + CNT_ONE) == CNT_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_frame <= '0;
      stable_cnt <= '0;
      keys       <= '0;
    end else begin
      stable_cnt <= stable_next;
      if (commit && !same) prev_frame <= frame;
      if (keys_upd) keys <= frame;
    end
  end

  // key_event is the valid, key_ack the ready: a press transfers on any edge
  // where both are high. key_code is stable while key_event is high; presses
  // arriving while a transfer is pending are dropped unless they coincide with
  // the accepting edge, in which case they become the next pending press.
  assign new_keys = frame & ~keys;
  assign ack_ok   = key_event && key_ack;

  always_comb begin
    new_low = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (new_keys[i]) new_low = 4'(i);
    end
  end

  always_comb begin
    event_next = key_event;
    code_next  = key_code;
    if (keys_upd && (new_keys != 16'h0) && (!key_event || ack_ok)) begin
      event_next = 1'b1;
      code_next  = new_low;
    end else if (ack_ok) begin
      event_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_event <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      key_event <= event_next;
      key_code  <= code_next;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model driven by held keys, a
// frame-level reference model and a per-cycle output compare.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DEB   = 3;
  localparam int FRAME = 4 * SD;
  localparam int LAT   = (DEB + 1) * FRAME + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [15:0] keys;
  logic        key_event;
  logic [3:0]  key_code;
  logic        key_ack = 1'b0;
  logic [15:0] held = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .reset(reset), .row_out(row_out), .col_in(col_in),
    .keys(keys), .key_event(key_event), .key_code(key_code), .key_ack(key_ack)
  );

  function automatic logic [3:0] key_of(input int r, input int c);
    case (r * 4 + c)
      0: key_of = 4'h1;   1: key_of = 4'h2;   2: key_of = 4'h3;   3: key_of = 4'hC;
      4: key_of = 4'h4;   5: key_of = 4'h5;   6: key_of = 4'h6;   7: key_of = 4'hD;
      8: key_of = 4'h7;   9: key_of = 4'h8;   10: key_of = 4'h9;  11: key_of = 4'hE;
      12: key_of = 4'hA;  13: key_of = 4'h0;  14: key_of = 4'hB;  default: key_of = 4'hF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Keypad: a held key shorts its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && held[key_of(r, c)]) col_in[c] = 1'b0;
  end

  // Reference model: edge n samples row (n/SD)%4 when n%SD==SD-1, seeing the
  // keys held two edges earlier; keys follows a frame once DEB identical
  // frames in a row have been seen.
  int          m_edges;
  logic [15:0] h1, h2, m_acc, m_keys;
  logic        m_event;
  logic [3:0]  m_code;
  logic [15:0] frames [$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_edges = 0; h1 = '0; h2 = '0; m_acc = '0;
      m_keys = '0; m_event = 1'b0; m_code = 4'h0;
      frames.delete();
    end else begin
      if (m_edges % SD == SD - 1) begin
        int r;
        r = (m_edges / SD) % 4;
        for (int c = 0; c < 4; c++) m_acc[key_of(r, c)] = h2[key_of(r, c)];
        if (r == 3) begin
          int run;
          logic upd, acc;
          logic [15:0] nw;
          frames.push_back(m_acc);
          if (frames.size() > DEB + 1) void'(frames.pop_front());
          run = 0;
          for (int i = frames.size() - 1; i >= 0; i--) begin
            if (frames[i] == m_acc) run++;
            else break;
          end
          upd = (run == DEB);
          nw  = m_acc & ~m_keys;
          acc = m_event && key_ack;
          if (upd && nw != 0 && (!m_event || acc)) begin
            m_event = 1'b1;
            for (int i = 15; i >= 0; i--) if (nw[i]) m_code = 4'(i);
          end else if (acc) begin
            m_event = 1'b0;
          end
          if (upd) m_keys = m_acc;
        end else if (m_event && key_ack) begin
          m_event = 1'b0;
        end
      end else if (m_event && key_ack) begin
        m_event = 1'b0;
      end
      h2 = h1;
      h1 = held;
      m_edges++;
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_row;
    exp_row = ~(4'b0001 << ((m_edges / SD) % 4));
    check("outputs", 32'({row_out, keys, key_event, key_code}),
          32'({exp_row, m_keys, m_event, m_code}));
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  logic [3:0] row_seq [5];

  initial begin
    row_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    #2 reset = 1'b0;
    wait_cycles(2);
    check("reset_row", 32'(row_out), 32'(4'b1110));
    check("reset_keys", 32'(keys), 32'h0);
    check("reset_event", 32'({key_event, key_code}), 32'h0);
    reset = 1'b1;

    // Scan order with no keys held.
    @(negedge clk);
    check("scan_row0", 32'(row_out), 32'(row_seq[0]));
    for (int i = 1; i < 5; i++) begin
      wait_cycles(i == 1 ? 3 : 4);
      check("scan_row", 32'(row_out), 32'(row_seq[i]));
    end
    check("scan_quiet", 32'({keys, key_event}), 32'h0);
    wait_cycles(5);
    #2 reset = 1'b0;
    #1 check("async_reset_row", 32'(row_out), 32'(4'b1110));
    @(negedge clk);
    reset = 1'b1;

    // Single press of key 0 (row 3, col 1), then acknowledge.
    held[0] = 1'b1;
    wait_cycles(LAT);
    check("press0_keys", 32'(keys), 32'h0001);
    check("press0_event", 32'({key_event, key_code}), 32'h10);
    pulse_ack();
    check("press0_ack", 32'({key_event, keys}), 32'h0001);
    held = '0;
    wait_cycles(LAT);
    check("release0", 32'({keys, key_event}), 32'h0);

    // Bounce on key 5, then hold.
    for (int i = 0; i < 6; i++) begin
      held[5] = (i % 2 == 0);
      wait_cycles(FRAME);
    end
    check("bounce_keys", 32'(keys), 32'h0);
    held[5] = 1'b1;
    wait_cycles(LAT);
    check("bounce_hold", 32'(keys), 32'h0020);
    check("bounce_code", 32'({key_event, key_code}), 32'h15);
    pulse_ack();
    held = '0;
    wait_cycles(LAT);
    check("release5", 32'({keys, key_event}), 32'h0);

    // C and 3 together, then 7 while the event is still pending.
    held[12] = 1'b1;
    held[3]  = 1'b1;
    wait_cycles(LAT);
    check("multi_keys", 32'(keys), 32'h1008);
    check("multi_code", 32'({key_event, key_code}), 32'h13);
    held[7] = 1'b1;
    wait_cycles(LAT);
    check("drop_keys", 32'(keys), 32'h1088);
    check("drop_code", 32'({key_event, key_code}), 32'h13);

    // Ack on the very edge that commits key E.
    for (int i = 0; i < FRAME && (m_edges % FRAME) != 0; i++) @(negedge clk);
    held[14] = 1'b1;
    wait_cycles(3 * FRAME - 1);
    pulse_ack();
    check("collide_keys", 32'(keys), 32'h5088);
    check("collide_code", 32'({key_event, key_code}), 32'h1E);
    pulse_ack();
    check("collide_clear", 32'(key_event), 32'h0);

    held = '0;
    wait_cycles(LAT);
    check("release_all", 32'({keys, key_event}), 32'h0);

    // Random phase: stable blocks long enough to debounce, noisy blocks that
    // bounce, random acks, and one asynchronous reset at a random point.
    for (int blk = 0; blk < 30; blk++) begin
      bit noisy;
      noisy = ($urandom_range(0, 1) == 1);
      if (blk == 15) begin
        @(posedge clk);
        #($urandom_range(1, 4)) reset = 1'b0;
        #1 check("rand_reset", 32'({row_out, keys, key_event}), 32'({4'b1110, 17'h0}));
        @(negedge clk);
        reset = 1'b1;
      end
      if (!noisy) held[$urandom_range(0, 15)] ^= 1'b1;
      repeat (80) begin
        @(negedge clk);
        if (noisy && $urandom_range(0, 9) == 0) held[$urandom_range(0, 15)] ^= 1'b1;
        key_ack = ($urandom_range(0, 3) == 0);
      end
    end
    key_ack = 1'b0;
    held = '0;
    wait_cycles(LAT);
    check("final_keys", 32'(keys), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input side of the CHIP-8 system: scans a 4x4 hex matrix keypad, debounces it and drives the CPU `keys` bus.
- Also raises one-shot press events with a handshake, used by the CPU wait-for-key instruction (FX0A).
- Sits between the board keypad pins and `chip8_cpu`, on the single system clock.

Parameters:
- SCAN_DIV, 50000, clock cycles each row is driven (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_SCANS, 8, consecutive identical full-matrix frames required before `keys` updates; minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- row_out  output  4  matrix row drive, active-low, exactly one row low at a time
- col_in  input  4  matrix column sense, active-low, pulled up on board, asynchronous
- keys  output  16  debounced key state; keys[n]=1 means hex key n is held
- key_event  output  1  a new press is pending
- key_code  output  4  hex code of the pending press; valid while key_event=1
- key_ack  input  1  consumer acknowledge for key_event

Behaviour:
- Reset values (async, reset=0): row_out=4'b1110, keys=0, key_event=0, key_code=0. Prescaler, row index, frame buffers, stable counter and synchronizers are all cleared.
- Reset mid-scan aborts the frame. No partial frame is ever committed.
- col_in passes through a 2-flop synchronizer, which adds 2 cycles of latency.
- Scan timing:
  - A prescaler counts 0..SCAN_DIV-1.
  - row_out = ~(4'b0001 << row).
  - On the cycle where prescaler==SCAN_DIV-1:
    - The synced, inverted columns are stored as raw[row][c].
    - Then row advances 0→1→2→3→0.
  - One frame is 4*SCAN_DIV cycles.
- Key map (row,col)→hex:
  - row 0: 1 2 3 C
  - row 1: 4 5 6 D
  - row 2: 7 8 9 E
  - row 3: A 0 B F
- Frame commit at the sample of row 3:
  - If the mapped frame equals the previous frame, stable_cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise the previous frame is replaced by the new one and stable_cnt=1.
  - keys is written with the frame on the cycle stable_cnt becomes DEBOUNCE_SCANS. It is not rewritten while saturated.
- Multiple simultaneous keys are reported as-is. There is no ghost rejection.
- Latency: a clean press is reflected in keys within (DEBOUNCE_SCANS+1) frames + 3 cycles.
- Event logic, on a keys update:
  - new = keys_next & ~keys.
  - If new≠0 and key_event=0: key_event←1 and key_code←lowest set index of new.
  - If key_event=1 and key_ack=0: new presses are dropped, not queued.
- Acknowledge:
  - key_ack=1 while key_event=1 clears key_event on the next edge.
  - key_ack while key_event=0 is ignored.
  - A keys update with new≠0 in the same cycle as an accepted ack keeps key_event=1 and loads the new key_code.
- Releases never generate events. key_code holds its last value after clear.

Test Plan:
(All with SCAN_DIV=4 and DEBOUNCE_SCANS=3, so a frame is 16 cycles.)
- Reset and scan: release reset, no keys pressed.
  - row_out cycles 1110,1101,1011,0111, changing every 4 cycles.
  - keys=0 and key_event=0 throughout.
  - Asserting reset mid-row returns row_out=1110 asynchronously.
- Single press: hold the (row 3, col 1) contact, i.e. col_in[1]=0 while row_out=0111.
  - keys=16'h0001 within 4 frames + 3 cycles.
  - key_event=1 with key_code=0.
  - Pulse key_ack for 1 cycle: key_event=0 on the next cycle and keys stays 16'h0001.
- Bounce: toggle the key-5 contact every frame for 6 frames, then hold it.
  - keys stays 0 during toggling.
  - keys=16'h0020 exactly 3 stable frames after the hold begins.
- Multi-key and priority: press C and 3 in the same frame.
  - keys=16'h1008, key_code=3.
  - Then, without ack, press 7: keys=16'h1088 and key_code stays 3 (the 7 press is dropped).
- Ack/press collision: with key_event pending, assert key_ack in the cycle keys gains key E.
  - key_event stays 1 and key_code=4'hE.
- Release: release all keys.
  - keys=0 after 3 stable frames.
  - No key_event is raised.
